// File: rtl/usb_trans_ctrl.sv
// rtl/usb_trans_ctrl.sv - USB device transaction controller: token decode, data toggles, handshakes.
// Sequences IN/OUT/SETUP transactions per endpoint with bus turnaround and response timeouts.
module usb_trans_ctrl #(
   parameter int EP_N        = 4,
   parameter int TURN_CYC    = 8,
   parameter int TIMEOUT_CYC = 72
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            usb_reset,
   input  logic            rx_pid_valid,
   input  logic [3:0]      rx_pid,
   input  logic [3:0]      rx_ep,
   input  logic            rx_addr_match,
   input  logic            rx_tok_ok,
   input  logic            rx_data_done,
   input  logic            rx_crc_err,
   input  logic            tx_busy,
   output logic            tx_start,
   output logic [3:0]      tx_pid,
   output logic [3:0]      ep_sel,
   input  logic [EP_N-1:0] ep_in_ready,
   input  logic [EP_N-1:0] ep_out_ready,
   input  logic [EP_N-1:0] ep_stall,
   output logic            in_ack,
   output logic            out_commit,
   output logic            setup_rx
);

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   localparam int MAX_CYC = (TURN_CYC > TIMEOUT_CYC) ? TURN_CYC : TIMEOUT_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_IN_TURN, S_IN_TX, S_IN_WAIT_HS,
      S_RX_WAIT_DATA, S_RX_DATA, S_HS_TURN, S_HS_TX
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      toggle_q, toggle_d;
   logic [3:0]       tx_pid_q, tx_pid_d;
   logic [3:0]       ep_sel_q, ep_sel_d;
   logic             is_setup_q, is_setup_d;
   logic             data_tog_q, data_tog_d;
   logic             tx_busy_q;

   // Endpoint vectors widened to 16 so the 4-bit endpoint number indexes them directly.
   logic [15:0] stall_x, in_rdy_x, out_rdy_x;
   assign stall_x   = 16'(ep_stall);
   assign in_rdy_x  = 16'(ep_in_ready);
   assign out_rdy_x = 16'(ep_out_ready);

   logic ep_ok, is_token, tok_hit, tx_fall, cur_tog, is_data;
   assign ep_ok    = ({1'b0, rx_ep} < 5'(EP_N));
   assign is_token = (rx_pid == PID_OUT) || (rx_pid == PID_IN) || (rx_pid == PID_SETUP);
   assign tok_hit  = rx_pid_valid && rx_addr_match && rx_tok_ok && ep_ok && is_token;
   assign is_data  = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
   assign tx_fall  = tx_busy_q && !tx_busy;
   assign cur_tog  = toggle_q[ep_sel_q];

   assign tx_pid = tx_pid_q;
   assign ep_sel = ep_sel_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         toggle_q   <= '0;
         tx_pid_q   <= 4'b0000;
         ep_sel_q   <= 4'd0;
         is_setup_q <= 1'b0;
         data_tog_q <= 1'b0;
         tx_busy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         toggle_q   <= toggle_d;
         tx_pid_q   <= tx_pid_d;
         ep_sel_q   <= ep_sel_d;
         is_setup_q <= is_setup_d;
         data_tog_q <= data_tog_d;
         tx_busy_q  <= tx_busy;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      toggle_d   = toggle_q;
      tx_pid_d   = tx_pid_q;
      ep_sel_d   = ep_sel_q;
      is_setup_d = is_setup_q;
      data_tog_d = data_tog_q;
      tx_start   = 1'b0;
      in_ack     = 1'b0;
      out_commit = 1'b0;
      setup_rx   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tok_hit) begin
               ep_sel_d = rx_ep;
               cnt_d    = '0;
               if (rx_pid == PID_IN) begin
                  if (stall_x[rx_ep]) begin
                     tx_pid_d = PID_STALL;
                     state_d  = S_HS_TURN;
                  end else if (in_rdy_x[rx_ep]) begin
                     tx_pid_d = toggle_q[rx_ep] ? PID_DATA1 : PID_DATA0;
                     state_d  = S_IN_TURN;
                  end else begin
                     tx_pid_d = PID_NAK;
                     state_d  = S_HS_TURN;
                  end
               end else begin
                  is_setup_d = (rx_pid == PID_SETUP);
                  state_d    = S_RX_WAIT_DATA;
               end
            end
         end
         S_IN_TURN, S_HS_TURN: begin
            // Hold at the last turnaround count until the transmitter is free.
            if (cnt_q == TURN_LAST) begin
               if (!tx_busy) begin
                  tx_start = 1'b1;
                  state_d  = (state_q == S_IN_TURN) ? S_IN_TX : S_HS_TX;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_IN_TX: begin
            if (tx_fall) begin
               cnt_d   = '0;
               state_d = S_IN_WAIT_HS;
            end
         end
         S_IN_WAIT_HS: begin
            if (rx_pid_valid) begin
               state_d = S_IDLE;
               if (rx_pid == PID_ACK) begin
                  in_ack             = 1'b1;
                  toggle_d[ep_sel_q] = !cur_tog;
               end
            end else if (cnt_q == TMO_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RX_WAIT_DATA: begin
            if (rx_pid_valid) begin
               if (is_data) begin
                  data_tog_d = rx_pid[3];
                  state_d    = S_RX_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (cnt_q == TMO_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RX_DATA: begin
            if (rx_data_done) begin
               if (rx_crc_err) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = S_HS_TURN;
                  if (is_setup_q) begin
                     // SETUP must always be accepted, even on a halted endpoint.
                     tx_pid_d           = PID_ACK;
                     out_commit         = 1'b1;
                     setup_rx           = 1'b1;
                     toggle_d[ep_sel_q] = 1'b1;
                  end else if (stall_x[ep_sel_q]) begin
                     tx_pid_d = PID_STALL;
                  end else if (!out_rdy_x[ep_sel_q]) begin
                     tx_pid_d = PID_NAK;
                  end else begin
                     tx_pid_d = PID_ACK;
                     if (data_tog_q == cur_tog) begin
                        out_commit         = 1'b1;
                        toggle_d[ep_sel_q] = !cur_tog;
                     end
                  end
               end
            end
         end
         S_HS_TX: begin
            if (tx_fall) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (usb_reset) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         toggle_d   = '0;
         tx_pid_d   = 4'b0000;
         ep_sel_d   = 4'd0;
         is_setup_d = 1'b0;
         data_tog_d = 1'b0;
         tx_start   = 1'b0;
         in_ack     = 1'b0;
         out_commit = 1'b0;
         setup_rx   = 1'b0;
      end
   end

endmodule

// File: tb/tb_usb_trans_ctrl.sv
// tb/tb_usb_trans_ctrl.sv - scoreboard bench for usb_trans_ctrl.
// Directed transactions push expected tx_start/in_ack/out_commit events; a monitor pops and compares.
module tb_usb_trans_ctrl;

   localparam int TURN = 8;
   localparam int TMO  = 72;
   localparam int BUSY = 10;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   localparam int K_TX     = 0;
   localparam int K_INACK  = 1;
   localparam int K_COMMIT = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       usb_reset;
   logic       rx_pid_valid;
   logic [3:0] rx_pid;
   logic [3:0] rx_ep;
   logic       rx_addr_match;
   logic       rx_tok_ok;
   logic       rx_data_done;
   logic       rx_crc_err;
   logic       tx_busy;
   logic       tx_start;
   logic [3:0] tx_pid;
   logic [3:0] ep_sel;
   logic [3:0] ep_in_ready;
   logic [3:0] ep_out_ready;
   logic [3:0] ep_stall;
   logic       in_ack;
   logic       out_commit;
   logic       setup_rx;

   usb_trans_ctrl #(.EP_N(4), .TURN_CYC(TURN), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .usb_reset(usb_reset),
      .rx_pid_valid(rx_pid_valid), .rx_pid(rx_pid), .rx_ep(rx_ep),
      .rx_addr_match(rx_addr_match), .rx_tok_ok(rx_tok_ok),
      .rx_data_done(rx_data_done), .rx_crc_err(rx_crc_err),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_pid(tx_pid), .ep_sel(ep_sel),
      .ep_in_ready(ep_in_ready), .ep_out_ready(ep_out_ready), .ep_stall(ep_stall),
      .in_ack(in_ack), .out_commit(out_commit), .setup_rx(setup_rx)
   );

   always #10 clk = ~clk;

   typedef struct {
      int         kind;
      logic [3:0] val;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: busy for BUSY cycles after each tx_start.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (BUSY) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_start) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL tx_start: unexpected, pid=%b cyc=%0d", tx_pid, cyc);
            end else begin
               e = sb.pop_front();
               if (e.kind != K_TX || e.val !== tx_pid || e.cyc != cyc || tx_busy) begin
                  n_fail++;
                  $display("FAIL tx_start: got pid=%b cyc=%0d busy=%b, expected kind=%0d pid=%b cyc=%0d busy=0",
                           tx_pid, cyc, tx_busy, e.kind, e.val, e.cyc);
               end
            end
         end
         if (in_ack) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL in_ack: unexpected at cyc=%0d", cyc);
            end else begin
               e = sb.pop_front();
               if (e.kind != K_INACK || e.cyc != cyc) begin
                  n_fail++;
                  $display("FAIL in_ack: got in_ack at cyc=%0d, expected kind=%0d cyc=%0d", cyc, e.kind, e.cyc);
               end
            end
         end
         if (out_commit) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL out_commit: unexpected, setup_rx=%b cyc=%0d", setup_rx, cyc);
            end else begin
               e = sb.pop_front();
               if (e.kind != K_COMMIT || e.val[0] !== setup_rx || e.cyc != cyc) begin
                  n_fail++;
                  $display("FAIL out_commit: got setup_rx=%b cyc=%0d, expected kind=%0d setup_rx=%b cyc=%0d",
                           setup_rx, cyc, e.kind, e.val[0], e.cyc);
               end
            end
         end
         if (setup_rx && !out_commit) begin
            n_tests++;
            n_fail++;
            $display("FAIL setup_rx: got setup_rx=1 out_commit=0, expected both together");
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int k, input logic [3:0] v, input int c);
      exp_t x;
      x.kind = k;
      x.val  = v;
      x.cyc  = c;
      sb.push_back(x);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic tok(input logic [3:0] pid, input logic [3:0] ep, input logic am, input logic ok);
      @(posedge clk);
      #1;
      rx_pid        = pid;
      rx_ep         = ep;
      rx_addr_match = am;
      rx_tok_ok     = ok;
      rx_pid_valid  = 1'b1;
   endtask

   task automatic tok_end;
      @(posedge clk);
      #1;
      rx_pid_valid  = 1'b0;
      rx_addr_match = 1'b0;
      rx_tok_ok     = 1'b0;
   endtask

   task automatic out_start(input logic [3:0] tp, input logic [3:0] ep, input logic [3:0] dp, input logic crc);
      tok(tp, ep, 1'b1, 1'b1);
      tok_end();
      idle(2);
      tok(dp, 4'd0, 1'b0, 1'b0);
      tok_end();
      idle(3);
      @(posedge clk);
      #1;
      rx_data_done = 1'b1;
      rx_crc_err   = crc;
   endtask

   task automatic out_end;
      @(posedge clk);
      #1;
      rx_data_done = 1'b0;
      rx_crc_err   = 1'b0;
   endtask

   task automatic wait_tx;
      int n;
      n = 0;
      while (!tx_busy && n < 200) begin
         @(posedge clk);
         n++;
      end
      while (tx_busy && n < 400) begin
         @(posedge clk);
         n++;
      end
      n_tests++;
      if (n >= 200) begin
         n_fail++;
         $display("FAIL wait_tx: got no complete transmission in %0d cycles, expected one", n);
      end
      idle(3);
   endtask

   task automatic in_tok(input logic [3:0] ep, input logic [3:0] exp_pid);
      tok(PID_IN, ep, 1'b1, 1'b1);
      push(K_TX, exp_pid, cyc + TURN);
      tok_end();
   endtask

   task automatic host_ack;
      tok(PID_ACK, 4'd0, 1'b0, 1'b0);
      push(K_INACK, 4'd0, cyc);
      tok_end();
   endtask

   initial begin
      rst = 1'b1; usb_reset = 1'b0;
      rx_pid_valid = 1'b0; rx_pid = 4'd0; rx_ep = 4'd0;
      rx_addr_match = 1'b0; rx_tok_ok = 1'b0;
      rx_data_done = 1'b0; rx_crc_err = 1'b0;
      ep_in_ready = 4'hF; ep_out_ready = 4'hF; ep_stall = 4'h0;
      idle(3);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_tx_start", 8'(tx_start), 8'h0);
      check("rst_tx_pid", 8'(tx_pid), 8'h0);
      check("rst_ep_sel", 8'(ep_sel), 8'h0);
      check("rst_in_ack", 8'(in_ack), 8'h0);
      check("rst_out_commit", 8'(out_commit), 8'h0);
      check("rst_setup_rx", 8'(setup_rx), 8'h0);

      // OUT ep1 DATA1 while toggle 0: ACK without commit
      out_start(PID_OUT, 4'd1, PID_DATA1, 1'b0);
      push(K_TX, PID_ACK, cyc + TURN);
      out_end();
      wait_tx();

      // IN ep1 DATA0, a stray token during turnaround, host ACK, then DATA1 left unacknowledged
      tok(PID_IN, 4'd1, 1'b1, 1'b1);
      push(K_TX, PID_DATA0, cyc + TURN);
      tok_end();
      idle(2);
      tok(PID_IN, 4'd2, 1'b1, 1'b1);
      tok_end();
      wait_tx();
      host_ack();
      idle(3);
      in_tok(4'd1, PID_DATA1);
      wait_tx();
      idle(TMO + 10);

      // IN ep2 timeout then retry with DATA0, acknowledged
      in_tok(4'd2, PID_DATA0);
      wait_tx();
      idle(TMO + 10);
      in_tok(4'd2, PID_DATA0);
      wait_tx();
      host_ack();
      idle(3);

      // OUT ep2 DATA1 matches toggle: commit + ACK; repeat mismatches: ACK only
      out_start(PID_OUT, 4'd2, PID_DATA1, 1'b0);
      push(K_COMMIT, 4'd0, cyc);
      push(K_TX, PID_ACK, cyc + TURN);
      out_end();
      wait_tx();
      out_start(PID_OUT, 4'd2, PID_DATA1, 1'b0);
      push(K_TX, PID_ACK, cyc + TURN);
      out_end();
      wait_tx();

      // SETUP ep0 on a halted endpoint: accepted, toggle forced to 1
      ep_stall = 4'b0001;
      out_start(PID_SETUP, 4'd0, PID_DATA0, 1'b0);
      push(K_COMMIT, 4'd1, cyc);
      push(K_TX, PID_ACK, cyc + TURN);
      out_end();
      wait_tx();
      ep_stall = 4'b0000;
      in_tok(4'd0, PID_DATA1);
      wait_tx();
      idle(TMO + 10);
      ep_out_ready = 4'b1110;
      out_start(PID_OUT, 4'd0, PID_DATA1, 1'b0);
      push(K_TX, PID_NAK, cyc + TURN);
      out_end();
      wait_tx();
      ep_out_ready = 4'hF;

      // STALL on OUT and IN, NAK on IN with no data
      ep_stall = 4'b1000;
      out_start(PID_OUT, 4'd3, PID_DATA0, 1'b0);
      push(K_TX, PID_STALL, cyc + TURN);
      out_end();
      wait_tx();
      in_tok(4'd3, PID_STALL);
      wait_tx();
      ep_stall = 4'b0000;
      ep_in_ready = 4'b1011;
      in_tok(4'd2, PID_NAK);
      wait_tx();
      ep_in_ready = 4'hF;

      // CRC error: silence; data timeout: silence
      out_start(PID_OUT, 4'd1, PID_DATA0, 1'b1);
      out_end();
      idle(40);
      tok(PID_OUT, 4'd1, 1'b1, 1'b1);
      tok_end();
      idle(TMO + 10);

      // Rejected tokens: address mismatch, endpoint out of range, bad CRC5
      tok(PID_IN, 4'd1, 1'b0, 1'b1);
      tok_end();
      idle(20);
      tok(PID_IN, 4'd5, 1'b1, 1'b1);
      tok_end();
      idle(20);
      tok(PID_IN, 4'd1, 1'b1, 1'b0);
      tok_end();
      idle(20);

      // usb_reset while waiting for the IN handshake
      in_tok(4'd1, PID_DATA1);
      wait_tx();
      @(negedge clk);
      check("pre_ureset_ep_sel", 8'(ep_sel), 8'h1);
      check("pre_ureset_tx_pid", 8'(tx_pid), 8'(PID_DATA1));
      @(posedge clk);
      #1 usb_reset = 1'b1;
      @(posedge clk);
      #1 usb_reset = 1'b0;
      @(negedge clk);
      check("ureset_ep_sel", 8'(ep_sel), 8'h0);
      check("ureset_tx_pid", 8'(tx_pid), 8'h0);
      tok(PID_ACK, 4'd0, 1'b0, 1'b0);
      tok_end();
      idle(5);
      in_tok(4'd1, PID_DATA0);
      wait_tx();
      idle(TMO + 10);

      check("sb_empty", 8'(sb.size()), 8'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_trans_ctrl.md
USB_TRANS_CTRL -- requirements
Module: usb_trans_ctrl

Interface
REQ-001 Parameter EP_N, default 4: number of implemented endpoints, 1..16.
REQ-002 Parameter TURN_CYC, default 8: clk cycles of bus turnaround before any device response (2 bit times at 48 MHz).
REQ-003 Parameter TIMEOUT_CYC, default 72: clk cycles to wait for a host packet after turnaround (18 bit times).
REQ-004 clk  in  1  48 MHz system clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 usb_reset  in  1  USB bus reset detected; synchronous clear.
REQ-007 rx_pid_valid  in  1  one-cycle strobe; rx_pid/rx_ep/rx_addr_match/rx_tok_ok valid.
REQ-008 rx_pid  in  4  received PID[3:0].
REQ-009 rx_ep  in  4  token endpoint field.
REQ-010 rx_addr_match  in  1  token address equals device address.
REQ-011 rx_tok_ok  in  1  token CRC5 and PID check passed.
REQ-012 rx_data_done  in  1  one-cycle strobe, end of data packet.
REQ-013 rx_crc_err  in  1  CRC16 error, valid with rx_data_done.
REQ-014 tx_busy  in  1  transmitter sending a packet.
REQ-015 tx_start  out  1  one-cycle request to transmit.
REQ-016 tx_pid  out  4  PID to transmit, held stable from tx_start until tx_busy falls.
REQ-017 ep_sel  out  4  latched endpoint of current transaction.
REQ-018 ep_in_ready  in  EP_N  IN data available per endpoint.
REQ-019 ep_out_ready  in  EP_N  OUT buffer free per endpoint.
REQ-020 ep_stall  in  EP_N  endpoint halted.
REQ-021 in_ack  out  1  pulse: IN data acknowledged, source may release buffer.
REQ-022 out_commit  out  1  pulse: OUT/SETUP data accepted, sink may commit buffer.
REQ-023 setup_rx  out  1  pulse with out_commit for SETUP transactions.

Function
REQ-024 PIDs: OUT 0001, IN 1001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
REQ-025 States: IDLE, IN_TURN, IN_TX, IN_WAIT_HS, RX_WAIT_DATA, RX_DATA, HS_TURN, HS_TX.
REQ-026 IDLE: token PID with rx_pid_valid & rx_addr_match & rx_tok_ok & rx_ep<EP_N latches ep_sel; any other strobe is ignored.
REQ-027 IN token: ep_stall -> HS_TURN with STALL; else ep_in_ready -> IN_TURN; else HS_TURN with NAK.
REQ-028 IN_TURN counts TURN_CYC cycles, then tx_start with tx_pid = DATA0/DATA1 per endpoint toggle, -> IN_TX.
REQ-029 IN_TX: on tx_busy falling -> IN_WAIT_HS, counter restarts.
REQ-030 IN_WAIT_HS: ACK within TIMEOUT_CYC -> in_ack pulse, toggle flips, IDLE; any other PID or timeout -> IDLE, toggle unchanged, no in_ack.
REQ-031 OUT/SETUP token -> RX_WAIT_DATA; DATA0/DATA1 strobe within TIMEOUT_CYC -> RX_DATA, PID latched; else IDLE.
REQ-032 RX_DATA: rx_data_done with rx_crc_err -> IDLE, no response, no pulses.
REQ-033 SETUP, good CRC: ACK regardless of ep_stall/ep_out_ready; out_commit+setup_rx pulse; toggle set to 1.
REQ-034 OUT, good CRC: ep_stall -> STALL; !ep_out_ready -> NAK; data PID != toggle -> ACK without out_commit; match -> ACK, out_commit, toggle flips.
REQ-035 HS_TURN waits TURN_CYC cycles, tx_start; HS_TX returns IDLE on tx_busy falling.
REQ-036 Pulses asserted exactly one cycle, on the cycle of the deciding event.
REQ-037 tx_start is never asserted while tx_busy is high.
REQ-038 Non-IDLE states ignore new token strobes.

Reset
REQ-039 rst: state IDLE, all toggles 0, counters 0, tx_start/in_ack/out_commit/setup_rx 0, tx_pid 0000, ep_sel 0.
REQ-040 usb_reset high: same values next clock edge, abandoning any transaction in progress.

Verification
REQ-041 IN ep1, ep_in_ready=1, toggle 0 -> tx_start 8 cycles after strobe with DATA0; host ACK -> in_ack, next IN sends DATA1.
REQ-042 IN ep2, no ACK within 72 cycles after tx_busy falls -> no in_ack, retry sends DATA0 again.
REQ-043 OUT ep1, DATA1 while toggle 0, good CRC -> ACK sent, no out_commit, toggle still 0.
REQ-044 SETUP ep0 with ep_stall[0]=1 -> ACK, out_commit+setup_rx, next IN sends DATA1; OUT with ep_out_ready=0 -> NAK.
REQ-045 Token with rx_addr_match=0 or rx_ep=5 (EP_N=4) -> no tx_start; usb_reset in IN_WAIT_HS -> IDLE, toggles 0.
